sonar_scan_sequencer: RTL and testbench
=======================================

SONAR_SCAN_SEQUENCER -- requirements
Module: sonar_scan_sequencer

Interface
REQ-001 The parameters SHALL be, one per line, as follows.
- PERIOD_CYCLES, 16777216, clocks per ping period.
- BURST_CYCLES, 524288, clocks of transmit burst at the start of each period.
- SAMPLE_DIV, 100, clocks between ADC sample triggers.
- DATA_WIDTH, 16, echo sample width.
- ANGLE_WIDTH, 8, signed beam angle width.
- ANGLE_MIN, -30, lowest sweep angle.
- ANGLE_MAX, 30, highest sweep angle.
- ANGLE_STEP, 1, sweep increment.
- DWELL_BURSTS, 8, periods spent at each angle.
REQ-002 The ports SHALL be, one per line, as follows.
- clk_in, input, 1, system clock.
- rst_in, input, 1, reset.
- enable_in, input, 1, run the scan.
- threshold_in, input, DATA_WIDTH, echo threshold (unsigned).
- sample_valid_in, input, 1, sample_in is valid.
- sample_in, input, DATA_WIDTH, aggregated receive sample.
- burst_active_out, output, 1, transmit gate.
- burst_start_out, output, 1, one-clock pulse at period start.
- sample_trigger_out, output, 1, ADC conversion strobe.
- angle_out, output, ANGLE_WIDTH signed, current beam angle.
- result_valid_out, output, 1, result strobe.
- result_angle_out, output, ANGLE_WIDTH signed, angle of the reported period.
- result_range_out, output, $clog2(PERIOD_CYCLES), echo time in clocks since burst start.
- result_hit_out, output, 1, echo found.
REQ-003 The block SHALL use one clock, clk_in; reset rst_in SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL implement the states IDLE, BURST, LISTEN and REPORT, driven by a period counter cnt that counts 0..PERIOD_CYCLES-1.
REQ-005 IDLE with enable_in=1 SHALL enter BURST on the next clock with cnt=0, and burst_start_out SHALL be high for that one cycle only.
REQ-006 The block SHALL be in BURST for cnt 0..BURST_CYCLES-1, LISTEN for cnt BURST_CYCLES..PERIOD_CYCLES-2, and REPORT for cnt=PERIOD_CYCLES-1.
REQ-007 burst_active_out SHALL be high exactly when the state is BURST.
REQ-008 sample_trigger_out SHALL pulse in LISTEN at cnt=BURST_CYCLES+k*SAMPLE_DIV, k>=0, and never outside LISTEN.
REQ-009 In LISTEN, the first cycle with sample_valid_in=1 and sample_in>threshold_in SHALL latch hit=1 and range=cnt; sample_valid_in outside LISTEN SHALL be ignored.
REQ-010 On the cycle after REPORT, result_valid_out SHALL be high for one clock, with result_angle_out=angle_out of that period, result_hit_out=hit, and result_range_out=range, or all-ones if there is no hit.
REQ-011 After REPORT the block SHALL go to BURST with cnt=0 if enable_in=1, else to IDLE; enable_in deasserted mid-period SHALL NOT cut the period short.
REQ-012 The dwell counter SHALL increment per completed period; after DWELL_BURSTS periods angle_out SHALL step by ANGLE_STEP in the current direction, taking effect at the next burst_start_out.
REQ-013 At a sweep limit the direction SHALL reverse: at ANGLE_MAX the next angle is ANGLE_MAX-ANGLE_STEP, and at ANGLE_MIN the next angle is ANGLE_MIN+ANGLE_STEP.
REQ-014 angle_out SHALL be constant between burst_start_out pulses, and the hit/range latches SHALL clear at each burst_start_out.

Reset
REQ-015 rst_in SHALL force state=IDLE, cnt=0, dwell=0, angle_out=0, direction=up, and all other outputs to 0 on the next clock, including when asserted mid-burst.
REQ-016 Parameter legality SHALL be ANGLE_MIN<=0<=ANGLE_MAX, BURST_CYCLES<PERIOD_CYCLES-1, SAMPLE_DIV>=1 and DWELL_BURSTS>=1.

Configuration
REQ-017 With SONAR_SCAN_PEAK_EN defined, range SHALL be the cnt of the largest qualifying sample in LISTEN, with ties going to the earliest; without it, range SHALL be the first threshold crossing per REQ-009.

Structure
REQ-018 Package sonar_pkg SHALL hold the state enum and the default period, burst, sample-divider and angle constants.
REQ-019 The angle bounce and dwell logic SHALL be the sub-module sonar_angle_stepper.

Verification
All scenarios use PERIOD=64, BURST=8, SAMPLE_DIV=4, DWELL=2, ANGLE -2..2.
REQ-020 Enable from reset -> burst_start_out at cnt 0, burst_active_out for 8 cycles, and triggers at cnt 8, 12, ..., 60.
REQ-021 threshold=100 with sample 150 valid at cnt 20 -> result_valid_out one cycle after cnt 63 with hit=1 and range=20.
REQ-022 No qualifying sample, plus a sample of 500 at cnt 3 (in BURST) -> hit=0 and range=63 (all-ones, 6 bits).
REQ-023 Twenty periods -> angle sequence 0,0,1,1,2,2,1,1,0,0,-1,-1,-2,-2,-1,-1,...
REQ-024 enable_in low at cnt 30 -> the period completes, result is reported, then IDLE with no further burst_start_out; rst_in at cnt 4 -> burst_active_out low on the next cycle.
REQ-025 With SONAR_SCAN_PEAK_EN, samples 150@cnt 20 and 300@cnt 40 -> range=40; without it -> range=20.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared state encoding and default timing/sweep constants for the sonar scan sequencer.
package sonar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_LISTEN = 2'd2,
        ST_REPORT = 2'd3
    } sonar_state_e;

    localparam int DEF_PERIOD_CYCLES = 16777216;
    localparam int DEF_BURST_CYCLES  = 524288;
    localparam int DEF_SAMPLE_DIV    = 100;
    localparam int DEF_ANGLE_MIN     = -30;
    localparam int DEF_ANGLE_MAX     = 30;
    localparam int DEF_ANGLE_STEP    = 1;
    localparam int DEF_DWELL_BURSTS  = 8;

endpackage

// File: rtl/sonar_angle_stepper.sv
// Beam angle generator: counts completed periods and bounces the angle between
// ANGLE_MIN and ANGLE_MAX, applying each step only when the next burst starts.
module sonar_angle_stepper #(
    parameter int ANGLE_WIDTH  = 8,
    parameter int ANGLE_MIN    = -30,
    parameter int ANGLE_MAX    = 30,
    parameter int ANGLE_STEP   = 1,
    parameter int DWELL_BURSTS = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          period_done_i,
    input  logic                          burst_start_i,
    output logic signed [ANGLE_WIDTH-1:0] angle_o
);

    localparam int DWELL_W = (DWELL_BURSTS > 1) ? $clog2(DWELL_BURSTS) : 1;
    localparam int AW2     = ANGLE_WIDTH + 2;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_BURSTS - 1);
    localparam logic signed [AW2-1:0] MAX_W  = AW2'(ANGLE_MAX);
    localparam logic signed [AW2-1:0] MIN_W  = AW2'(ANGLE_MIN);
    localparam logic signed [AW2-1:0] STEP_W = AW2'(ANGLE_STEP);

    logic [DWELL_W-1:0]            dwell_q, dwell_d;
    logic                          stepPending_q, stepPending_d;
    logic                          dirUp_q, dirUp_d;
    logic signed [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic signed [AW2-1:0]         angleWide, angleUp, angleDown;
    logic                          dwellWrap, stepNow;

    assign angleWide = {{2{angle_q[ANGLE_WIDTH-1]}}, angle_q};
    assign angleUp   = angleWide + STEP_W;
    assign angleDown = angleWide - STEP_W;
    assign dwellWrap = period_done_i && (dwell_q == DWELL_LAST);
    // A wrap while the sequencer idles is held until the next burst so the angle never moves mid-gap.
    assign stepNow   = burst_start_i && (stepPending_q || dwellWrap);

    always_comb begin
        dwell_d       = dwell_q;
        stepPending_d = stepNow ? 1'b0 : (stepPending_q || dwellWrap);
        angle_d       = angle_q;
        dirUp_d       = dirUp_q;
        if (period_done_i) begin
            dwell_d = dwellWrap ? '0 : dwell_q + DWELL_W'(1);
        end
        if (stepNow) begin
            if (dirUp_q) begin
                if (angleUp > MAX_W) begin
                    angle_d = angleDown[ANGLE_WIDTH-1:0];
                    dirUp_d = 1'b0;
                end else begin
                    angle_d = angleUp[ANGLE_WIDTH-1:0];
                end
            end else begin
                if (angleDown < MIN_W) begin
                    angle_d = angleUp[ANGLE_WIDTH-1:0];
                    dirUp_d = 1'b1;
                end else begin
                    angle_d = angleDown[ANGLE_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dwell_q       <= '0;
            stepPending_q <= 1'b0;
            dirUp_q       <= 1'b1;
            angle_q       <= '0;
        end else begin
            dwell_q       <= dwell_d;
            stepPending_q <= stepPending_d;
            dirUp_q       <= dirUp_d;
            angle_q       <= angle_d;
        end
    end

    assign angle_o = angle_q;

endmodule

// File: rtl/sonar_scan_sequencer.sv
// Ping period sequencer: burst, listen for the first echo above threshold, report.
// Define SONAR_SCAN_PEAK_EN to report the strongest echo instead of the first crossing.
module sonar_scan_sequencer
    import sonar_pkg::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int BURST_CYCLES  = DEF_BURST_CYCLES,
    parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
    parameter int DATA_WIDTH    = 16,
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = DEF_ANGLE_MIN,
    parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
    parameter int ANGLE_STEP    = DEF_ANGLE_STEP,
    parameter int DWELL_BURSTS  = DEF_DWELL_BURSTS
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 enable_in,
    input  logic [DATA_WIDTH-1:0]                threshold_in,
    input  logic                                 sample_valid_in,
    input  logic [DATA_WIDTH-1:0]                sample_in,
    output logic                                 burst_active_out,
    output logic                                 burst_start_out,
    output logic                                 sample_trigger_out,
    output logic signed [ANGLE_WIDTH-1:0]        angle_out,
    output logic                                 result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0]        result_angle_out,
    output logic [$clog2(PERIOD_CYCLES)-1:0]     result_range_out,
    output logic                                 result_hit_out
);

    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'(PERIOD_CYCLES - 2);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);

    if (ANGLE_MIN > 0 || ANGLE_MAX < 0 || BURST_CYCLES >= PERIOD_CYCLES - 1 ||
        SAMPLE_DIV < 1 || DWELL_BURSTS < 1) begin : g_param_check
        $error("sonar_scan_sequencer: illegal parameter combination");
    end

    sonar_state_e                  state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [DIV_W-1:0]              div_q, divNext;
    logic                          burstActive_q, burstStart_q, sampleTrigger_q;
    logic                          resultValid_q, resultHit_q;
    logic signed [ANGLE_WIDTH-1:0] resultAngle_q, angleNow;
    logic [CNT_W-1:0]              resultRange_q, range_q;
    logic                          hit_q;
    logic                          startBurst, qualify;

    assign startBurst = enable_in && (state_q == ST_IDLE || state_q == ST_REPORT);
    assign qualify    = (state_q == ST_LISTEN) && sample_valid_in && (sample_in > threshold_in);
    assign divNext    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    sonar_angle_stepper #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .ANGLE_MIN   (ANGLE_MIN),
        .ANGLE_MAX   (ANGLE_MAX),
        .ANGLE_STEP  (ANGLE_STEP),
        .DWELL_BURSTS(DWELL_BURSTS)
    ) u_stepper (
        .clk_i        (clk_in),
        .rst_i        (rst_in),
        .period_done_i(state_q == ST_REPORT),
        .burst_start_i(startBurst),
        .angle_o      (angleNow)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            div_q           <= '0;
            burstActive_q   <= 1'b0;
            burstStart_q    <= 1'b0;
            sampleTrigger_q <= 1'b0;
            resultValid_q   <= 1'b0;
            resultAngle_q   <= '0;
            resultRange_q   <= '0;
            resultHit_q     <= 1'b0;
        end else begin
            burstStart_q    <= 1'b0;
            sampleTrigger_q <= 1'b0;
            resultValid_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (startBurst) begin
                        state_q       <= ST_BURST;
                        burstStart_q  <= 1'b1;
                        burstActive_q <= 1'b1;
                    end
                end
                ST_BURST: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == BURST_LAST) begin
                        state_q         <= ST_LISTEN;
                        burstActive_q   <= 1'b0;
                        div_q           <= '0;
                        sampleTrigger_q <= 1'b1;
                    end
                end
                ST_LISTEN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LISTEN_LAST) begin
                        state_q <= ST_REPORT;
                    end else begin
                        div_q           <= divNext;
                        sampleTrigger_q <= (divNext == '0);
                    end
                end
                ST_REPORT: begin
                    cnt_q         <= '0;
                    resultValid_q <= 1'b1;
                    resultAngle_q <= angleNow;
                    resultHit_q   <= hit_q;
                    resultRange_q <= hit_q ? range_q : '1;
                    if (startBurst) begin
                        state_q       <= ST_BURST;
                        burstStart_q  <= 1'b1;
                        burstActive_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef SONAR_SCAN_PEAK_EN
    logic [DATA_WIDTH-1:0] peak_q;

    // Strict greater-than keeps the earliest sample when two peaks tie.
    always_ff @(posedge clk_in) begin
        if (rst_in || startBurst) begin
            hit_q   <= 1'b0;
            range_q <= '0;
            peak_q  <= '0;
        end else if (qualify && (!hit_q || sample_in > peak_q)) begin
            hit_q   <= 1'b1;
            range_q <= cnt_q;
            peak_q  <= sample_in;
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (rst_in || startBurst) begin
            hit_q   <= 1'b0;
            range_q <= '0;
        end else if (qualify && !hit_q) begin
            hit_q   <= 1'b1;
            range_q <= cnt_q;
        end
    end
`endif

    assign burst_active_out   = burstActive_q;
    assign burst_start_out    = burstStart_q;
    assign sample_trigger_out = sampleTrigger_q;
    assign angle_out          = angleNow;
    assign result_valid_out   = resultValid_q;
    assign result_angle_out   = resultAngle_q;
    assign result_range_out   = resultRange_q;
    assign result_hit_out     = resultHit_q;

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// Directed scoreboard bench for sonar_scan_sequencer with a small scan configuration
// (period 64, burst 8, sample divider 4, dwell 2, angles -2..2).
`timescale 1ns/1ps
module tb_sonar_scan_sequencer;

    localparam int PERIOD = 64;
    localparam int BURST  = 8;
    localparam int DIV    = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              enable;
    logic [15:0]       threshold;
    logic              sampleValid;
    logic [15:0]       sampleData;
    logic              burstActive, burstStart, sampleTrigger;
    logic signed [7:0] angle, resultAngle;
    logic              resultValid, resultHit;
    logic [5:0]        resultRange;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic signed [7:0] angle;
        logic              hit;
        logic [5:0]        range;
    } result_t;

    result_t scoreboard[$];
    bit      resultPending = 1'b0;

    int angleTable[22] = '{0, 0, 1, 1, 2, 2, 1, 1, 0, 0, -1, -1, -2, -2, -1, -1, 0, 0, 1, 1, 2, 2};
    int s1Cnt[8]  = '{3,   20,  20,  10,  7,   8,   20,  30};
    int s1Val[8]  = '{500, 150, 150, 100, 900, 120, 300, 50};
    int s2Cnt[8]  = '{-1,  -1,  40,  50,  62,  63,  40,  45};
    int s2Val[8]  = '{0,   0,   300, 101, 200, 900, 300, 70};
    int thrTab[8] = '{100, 100, 100, 100, 100, 100, 100, 60};

    sonar_scan_sequencer #(
        .PERIOD_CYCLES(PERIOD),
        .BURST_CYCLES (BURST),
        .SAMPLE_DIV   (DIV),
        .DATA_WIDTH   (16),
        .ANGLE_WIDTH  (8),
        .ANGLE_MIN    (-2),
        .ANGLE_MAX    (2),
        .ANGLE_STEP   (1),
        .DWELL_BURSTS (2)
    ) dut (
        .clk_in            (clock),
        .rst_in            (reset),
        .enable_in         (enable),
        .threshold_in      (threshold),
        .sample_valid_in   (sampleValid),
        .sample_in         (sampleData),
        .burst_active_out  (burstActive),
        .burst_start_out   (burstStart),
        .sample_trigger_out(sampleTrigger),
        .angle_out         (angle),
        .result_valid_out  (resultValid),
        .result_angle_out  (resultAngle),
        .result_range_out  (resultRange),
        .result_hit_out    (resultHit)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic valid, input logic [15:0] data,
                                 input logic [15:0] thr);
        enable      = en;
        sampleValid = valid;
        sampleData  = data;
        threshold   = thr;
    endtask

    task automatic doCycle();
        @(posedge clock);
        #1;
    endtask

    // Reference echo picker: first crossing, or strongest (earliest on ties) in peak mode.
    task automatic computeExpected(input int idx, output logic hit, output logic [5:0] range);
        int bestCnt, bestVal, c, v;
        hit = 1'b0;
        range = '1;
        bestCnt = 0;
        bestVal = 0;
        for (int k = 0; k < 2; k++) begin
            c = (k == 0) ? s1Cnt[idx] : s2Cnt[idx];
            v = (k == 0) ? s1Val[idx] : s2Val[idx];
            if (c >= BURST && c <= PERIOD - 2 && v > thrTab[idx]) begin
`ifdef SONAR_SCAN_PEAK_EN
                if (!hit || v > bestVal || (v == bestVal && c < bestCnt)) begin
`else
                if (!hit || c < bestCnt) begin
`endif
                    hit = 1'b1;
                    bestCnt = c;
                    bestVal = v;
                    range = 6'(c);
                end
            end
        end
    endtask

    task automatic popAndCompare();
        result_t e;
        if (scoreboard.size() == 0) return;
        e = scoreboard.pop_front();
        checkOutput("result_angle", resultAngle, e.angle);
        checkOutput("result_hit", resultHit, e.hit);
        checkOutput("result_range", resultRange, e.range);
    endtask

    task automatic runPeriod(input int p, input int dropAt);
        int      idx;
        result_t e;
        logic    valid;
        int      val;
        idx = p % 8;
        for (int c = 0; c < PERIOD; c++) begin
            doCycle();
            checkOutput("burst_start", burstStart, c == 0);
            checkOutput("burst_active", burstActive, c < BURST);
            checkOutput("sample_trigger", sampleTrigger,
                        (c >= BURST) && (c <= PERIOD - 2) && ((c - BURST) % DIV == 0));
            checkOutput("angle", angle, angleTable[p]);
            checkOutput("result_valid", resultValid, (c == 0) && resultPending);
            if (resultValid) popAndCompare();
            if (c == 0) begin
                computeExpected(idx, e.hit, e.range);
                e.angle = 8'(angleTable[p]);
                scoreboard.push_back(e);
                resultPending = 1'b1;
            end
            valid = (c == s1Cnt[idx]) || (c == s2Cnt[idx]);
            val   = (c == s1Cnt[idx]) ? s1Val[idx] : s2Val[idx];
            applyStimulus(!(dropAt >= 0 && c >= dropAt), valid,
                          valid ? 16'(val) : 16'hFFFF, 16'(thrTab[idx]));
        end
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'd0);
        repeat (3) doCycle();
        checkOutput("rst_burst_active", burstActive, 0);
        checkOutput("rst_burst_start", burstStart, 0);
        checkOutput("rst_trigger", sampleTrigger, 0);
        checkOutput("rst_angle", angle, 0);
        checkOutput("rst_result_valid", resultValid, 0);
        checkOutput("rst_result_range", resultRange, 0);

        reset = 1'b0;
        doCycle();
        checkOutput("idle_burst_active", burstActive, 0);
        checkOutput("idle_burst_start", burstStart, 0);

        applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'd100);
        for (int p = 0; p < 20; p++) runPeriod(p, -1);
        runPeriod(20, 30);

        doCycle();
        checkOutput("stop_result_valid", resultValid, 1);
        if (resultValid) popAndCompare();
        checkOutput("stop_burst_start", burstStart, 0);
        checkOutput("stop_burst_active", burstActive, 0);
        resultPending = 1'b0;
        for (int i = 0; i < 4; i++) begin
            doCycle();
            checkOutput("idle_no_start", burstStart, 0);
            checkOutput("idle_no_result", resultValid, 0);
            checkOutput("idle_no_trigger", sampleTrigger, 0);
            checkOutput("idle_angle_hold", angle, angleTable[20]);
        end

        applyStimulus(1'b1, 1'b0, 16'hFFFF, 16'd100);
        for (int c = 0; c <= 4; c++) begin
            doCycle();
            checkOutput("restart_burst_start", burstStart, c == 0);
            checkOutput("restart_burst_active", burstActive, 1);
            checkOutput("restart_angle", angle, angleTable[21]);
        end
        reset = 1'b1;
        doCycle();
        checkOutput("midrst_burst_active", burstActive, 0);
        checkOutput("midrst_burst_start", burstStart, 0);
        checkOutput("midrst_angle", angle, 0);
        checkOutput("midrst_result_valid", resultValid, 0);
        checkOutput("midrst_result_hit", resultHit, 0);
        checkOutput("midrst_result_angle", resultAngle, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'd0);
        doCycle();
        checkOutput("post_rst_burst_active", burstActive, 0);
        checkOutput("post_rst_burst_start", burstStart, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
